sort_engine: RTL

Parametrised in-place bubble-sort engine that sorts the first `len` words of an external synchronous single-port RAM (Quartus altsyncram-style, one-cycle read latency). It generalises the fixed 8-bit/256-entry ascending sorter: data width, address width, signedness and sort direction are configurable, and it reports a swap count. It sits between the board-level control logic (KEY/SW decode) and the sample RAM.

---
 rtl/sort_engine.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/sort_engine.sv
// sort_engine: in-place bubble sort over the first `len` words of an external
// synchronous single-port RAM with one-cycle read latency.
// Optional feature macro: SORT_EARLY_EXIT_EN -- when defined, a per-pass swap
// flag is kept and the sort finishes after the first pass with no swaps.
// Every output is driven straight from a flop, so nothing on mem_rdata can
// reach an output port combinationally.
module sort_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              desc,
  output logic              busy,
  output logic              done,
  output logic [2*ADDR_W:0] swap_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CMP,
    WR0,
    WR1,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2*ADDR_W:0] SWAP_ONE = {{(2*ADDR_W){1'b0}}, 1'b1};

  state_t state_q, state_d;

  // Sort bookkeeping: pair index, last index of the current pass, first
  // element of the pair, latched direction and running swap total.
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W:0]   lim_q, lim_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              desc_q, desc_d;
  logic [2*ADDR_W:0] swap_count_q, swap_count_d;

`ifdef SORT_EARLY_EXIT_EN
  logic pass_swap_q, pass_swap_d;
`endif

  // Registered versions of every output port.
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] i_next;
  logic            a_gt_b;
  logic            a_lt_b;
  logic            need_swap;
  logic            advance;
  logic            more_pairs;
  logic            sort_end;

  // Pair compare and the end-of-pair / end-of-pass decisions.
  always_comb begin
    len_clamped = (len > DEPTH) ? DEPTH : len;
    i_next      = {1'b0, i_q} + ONE;
    if (SIGNED) begin
      a_gt_b = $signed(a_q) > $signed(mem_rdata);
      a_lt_b = $signed(a_q) < $signed(mem_rdata);
    end else begin
      a_gt_b = a_q > mem_rdata;
      a_lt_b = a_q < mem_rdata;
    end
    // Equal values never swap, which keeps the sort stable.
    need_swap  = desc_q ? a_lt_b : a_gt_b;
    advance    = ((state_q == CMP) && !need_swap) || (state_q == WR1);
    more_pairs = i_next < lim_q;
`ifdef SORT_EARLY_EXIT_EN
    // A swap in the final pair of the pass counts towards this pass.
    sort_end   = (lim_q == ONE) || !(pass_swap_q || (state_q == WR1));
`else
    sort_end   = (lim_q == ONE);
`endif
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: read pair, compare, optionally write back both halves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len_clamped <= ONE) ? DONE : RD0;
        end
      end
      RD0: state_d = RD1;
      RD1: state_d = CMP;
      CMP: begin
        if (need_swap) begin
          state_d = WR0;
        end else begin
          state_d = (more_pairs || !sort_end) ? RD0 : DONE;
        end
      end
      WR0: state_d = WR1;
      WR1: state_d = (more_pairs || !sort_end) ? RD0 : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch request, capture first element, count swaps,
  // step through pairs and shrink the pass after each sweep.
  always_comb begin
    i_d          = i_q;
    lim_d        = lim_q;
    a_d          = a_q;
    desc_d       = desc_q;
    swap_count_d = swap_count_q;
`ifdef SORT_EARLY_EXIT_EN
    pass_swap_d  = pass_swap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          desc_d       = desc;
          lim_d        = len_clamped - ONE;
          i_d          = '0;
          swap_count_d = '0;
`ifdef SORT_EARLY_EXIT_EN
          pass_swap_d  = 1'b0;
`endif
        end
      end
      RD1: a_d = mem_rdata;
      WR1: begin
        swap_count_d = swap_count_q + SWAP_ONE;
`ifdef SORT_EARLY_EXIT_EN
        pass_swap_d  = 1'b1;
`endif
      end
      default: ;
    endcase
    if (advance) begin
      if (more_pairs) begin
        i_d = i_q + ADDR_ONE;
      end else if (!sort_end) begin
        lim_d = lim_q - ONE;
        i_d   = '0;
`ifdef SORT_EARLY_EXIT_EN
        pass_swap_d = 1'b0;
`endif
      end
    end
  end

  // Output next values, decoded from the state being entered so the
  // registered outputs line up with that state's cycle.
  always_comb begin
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
    mem_we_d    = (state_d == WR0) || (state_d == WR1);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      RD0, WR0: mem_addr_d = i_d;
      RD1, WR1: mem_addr_d = i_d + ADDR_ONE;
      default: ;
    endcase
    // Entering WR0 from CMP: mem_rdata still holds the second element.
    if (state_d == WR0) begin
      mem_wdata_d = mem_rdata;
    end else if (state_d == WR1) begin
      mem_wdata_d = a_q;
    end
  end

  // Datapath and output registers; reset drops mem_we and busy at once.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      i_q          <= '0;
      lim_q        <= '0;
      a_q          <= '0;
      desc_q       <= 1'b0;
      swap_count_q <= '0;
`ifdef SORT_EARLY_EXIT_EN
      pass_swap_q  <= 1'b0;
`endif
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      i_q          <= i_d;
      lim_q        <= lim_d;
      a_q          <= a_d;
      desc_q       <= desc_d;
      swap_count_q <= swap_count_d;
`ifdef SORT_EARLY_EXIT_EN
      pass_swap_q  <= pass_swap_d;
`endif
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_count = swap_count_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule
